// File: rtl/lvds_rx_align_ctrl.sv
// Word-alignment controller for a 7:1 LVDS receiver: bitslips the deserializers
// until the clock lane reads CLK_PATTERN, holds lock with hysteresis, forwards lane data.
module lvds_rx_align_ctrl #(
    parameter logic [6:0]  CLK_PATTERN   = 7'b1100011,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned LOSS_COUNT    = 4,
    parameter int unsigned MAX_ATTEMPTS  = 14
) (
    input  logic       I_clk_1x,
    input  logic       I_rst_n,
    input  logic       I_enable,
    input  logic [6:0] I_clk_lane_data,
    input  logic [6:0] I_lane_data0,
    input  logic [6:0] I_lane_data1,
    input  logic [6:0] I_lane_data2,
    input  logic [6:0] I_lane_data3,
    output logic       O_bitslip,
    output logic       O_align_valid0,
    output logic       O_align_valid1,
    output logic       O_align_valid2,
    output logic       O_align_valid3,
    output logic [6:0] O_align_data0,
    output logic [6:0] O_align_data1,
    output logic [6:0] O_align_data2,
    output logic [6:0] O_align_data3,
    output logic       O_locked,
    output logic       O_fail,
    output logic [2:0] O_slip_pos
);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned GOOD_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W    = $clog2(LOSS_COUNT + 1);
    localparam int unsigned ATT_W    = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [GOOD_W-1:0]   GOOD_MAX    = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0]   GOOD_LAST   = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]    BAD_LAST    = BAD_W'(LOSS_COUNT - 1);
    localparam logic [ATT_W-1:0]    ATT_MAX     = ATT_W'(MAX_ATTEMPTS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_SLIP   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_VERIFY = 3'd4;
    localparam logic [2:0] ST_LOCKED = 3'd5;
    localparam logic [2:0] ST_FAIL   = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]    bad_cnt_q, bad_cnt_d;
    logic [ATT_W-1:0]    attempts_q, attempts_d;
    logic [2:0]          slip_pos_q, slip_pos_d;
    logic                bitslip_q, bitslip_d;
    logic                locked_q, locked_d;
    logic                fail_q, fail_d;
    logic [3:0][6:0]     data_q, data_d;
    logic                clk_match;

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        attempts_d   = attempts_q;
        slip_pos_d   = slip_pos_q;
        clk_match    = (I_clk_lane_data == CLK_PATTERN);
        data_d       = {I_lane_data3, I_lane_data2, I_lane_data1, I_lane_data0};

        case (state_q)
            ST_IDLE: begin
                settle_cnt_d = '0;
                good_cnt_d   = '0;
                bad_cnt_d    = '0;
                attempts_d   = '0;
                state_d      = ST_CHECK;
            end
            ST_CHECK: begin
                if (clk_match) begin
                    state_d    = ST_VERIFY;
                    good_cnt_d = GOOD_W'(1);
                end else if (attempts_q == ATT_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_SLIP;
                end
            end
            ST_SLIP: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
            end
            ST_SETTLE: begin
                if (settle_cnt_q >= SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            ST_VERIFY: begin
                if (clk_match) begin
                    if (good_cnt_q != GOOD_MAX) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                    if (good_cnt_q >= GOOD_LAST) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    good_cnt_d = '0;
                    state_d    = ST_SLIP;
                end
            end
            ST_LOCKED: begin
                if (clk_match) begin
                    bad_cnt_d = '0;
                end else if (bad_cnt_q >= BAD_LAST) begin
                    state_d    = ST_CHECK;
                    bad_cnt_d  = '0;
                    good_cnt_d = '0;
                    attempts_d = '0;
                end else begin
                    bad_cnt_d = bad_cnt_q + BAD_W'(1);
                end
            end
            ST_FAIL:  state_d = ST_FAIL;
            default:  state_d = ST_IDLE;
        endcase

        // Enable wins over everything, so a dropped enable never emits a slip
        if (!I_enable) begin
            state_d = ST_IDLE;
        end

        if (state_d == ST_SLIP) begin
            slip_pos_d = (slip_pos_q == 3'd6) ? 3'd0 : slip_pos_q + 3'd1;
            if (attempts_q != ATT_MAX) begin
                attempts_d = attempts_q + ATT_W'(1);
            end
        end
        if (state_d == ST_LOCKED) begin
            attempts_d = '0;
        end

        bitslip_d = (state_d == ST_SLIP);
        locked_d  = (state_d == ST_LOCKED);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            attempts_q   <= '0;
            slip_pos_q   <= '0;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            attempts_q   <= attempts_d;
            slip_pos_q   <= slip_pos_d;
            bitslip_q    <= bitslip_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            data_q       <= data_d;
        end
    end

    assign O_bitslip      = bitslip_q;
    assign O_locked       = locked_q;
    assign O_fail         = fail_q;
    assign O_slip_pos     = slip_pos_q;
    assign O_align_valid0 = locked_q;
    assign O_align_valid1 = locked_q;
    assign O_align_valid2 = locked_q;
    assign O_align_valid3 = locked_q;
    assign O_align_data0  = data_q[0];
    assign O_align_data1  = data_q[1];
    assign O_align_data2  = data_q[2];
    assign O_align_data3  = data_q[3];

endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Bench for lvds_rx_align_ctrl: a rotating clock-lane model reacts to bitslips,
// and a queue scoreboard checks the registered lane data path.
module tb_lvds_rx_align_ctrl;
    localparam logic [6:0] PAT = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [6:0] clk_word;
    logic [6:0] lane0 = '0, lane1 = '0, lane2 = '0, lane3 = '0;

    logic       O_bitslip, O_locked, O_fail;
    logic       O_align_valid0, O_align_valid1, O_align_valid2, O_align_valid3;
    logic [6:0] O_align_data0, O_align_data1, O_align_data2, O_align_data3;
    logic [2:0] O_slip_pos;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rot = 0;
    bit         rotate_en = 1'b1;
    bit         use_force = 1'b0;
    logic [6:0] force_word = '0;
    int         pulses = 0;
    int         exp_slip = 0;
    int         pulse_cyc[$];
    logic [27:0] data_sb[$];

    lvds_rx_align_ctrl dut (
        .I_clk_1x        (clk),
        .I_rst_n         (rst_n),
        .I_enable        (en),
        .I_clk_lane_data (clk_word),
        .I_lane_data0    (lane0),
        .I_lane_data1    (lane1),
        .I_lane_data2    (lane2),
        .I_lane_data3    (lane3),
        .O_bitslip       (O_bitslip),
        .O_align_valid0  (O_align_valid0),
        .O_align_valid1  (O_align_valid1),
        .O_align_valid2  (O_align_valid2),
        .O_align_valid3  (O_align_valid3),
        .O_align_data0   (O_align_data0),
        .O_align_data1   (O_align_data1),
        .O_align_data2   (O_align_data2),
        .O_align_data3   (O_align_data3),
        .O_locked        (O_locked),
        .O_fail          (O_fail),
        .O_slip_pos      (O_slip_pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] rotl7(input logic [6:0] w, input int n);
        logic [6:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
        return r;
    endfunction

    assign clk_word = use_force ? force_word : rotl7(PAT, rot);

    // Deserializer model: each bitslip pulse moves the word one position toward alignment
    always @(negedge clk) begin
        if (O_bitslip === 1'b1) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            exp_slip = (exp_slip + 1) % 7;
            if (rotate_en) rot = (rot == 0) ? 6 : rot - 1;
        end
    end

    task automatic wait_locked(input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (O_locked === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_data_path(input int n, input logic [3:0] exp_valid);
        logic [27:0] exp;
        data_sb.delete();
        for (int i = 0; i < n; i++) begin
            lane0 = 7'($urandom);
            lane1 = 7'($urandom);
            lane2 = 7'($urandom);
            lane3 = 7'($urandom);
            data_sb.push_back({lane3, lane2, lane1, lane0});
            @(negedge clk);
            exp = data_sb.pop_front();
            n_tests++;
            if ({O_align_data3, O_align_data2, O_align_data1, O_align_data0} !== exp) begin
                n_fail++;
                $display("FAIL data_path[%0d]: got %h expected %h", i,
                         {O_align_data3, O_align_data2, O_align_data1, O_align_data0}, exp);
            end
            n_tests++;
            if ({O_align_valid3, O_align_valid2, O_align_valid1, O_align_valid0} !== exp_valid) begin
                n_fail++;
                $display("FAIL valid[%0d]: got %b expected %b", i,
                         {O_align_valid3, O_align_valid2, O_align_valid1, O_align_valid0}, exp_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        rot = 0;
        use_force = 1'b0;
        lane0 = 7'h11; lane1 = 7'h22; lane2 = 7'h33; lane3 = 7'h44;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({O_bitslip, O_locked, O_fail, O_slip_pos, O_align_valid3, O_align_valid2,
             O_align_valid1, O_align_valid0} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0", {O_bitslip, O_locked, O_fail, O_slip_pos});
        end
        n_tests++;
        if ({O_align_data3, O_align_data2, O_align_data1, O_align_data0} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {O_align_data3, O_align_data2, O_align_data1, O_align_data0});
        end
        rst_n = 1'b1;
        exp_slip = 0;
        pulses = 0;
        @(negedge clk);
        n_tests++;
        if ({O_bitslip, O_locked, O_fail, O_slip_pos} !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 0", {O_bitslip, O_locked, O_fail, O_slip_pos});
        end
    endtask

    task automatic test_aligned();
        int k;
        rot = 0;
        use_force = 1'b0;
        pulses = 0;
        en = 1'b1;
        wait_locked(40, k);
        n_tests++;
        if (k != 17) begin
            n_fail++;
            $display("FAIL aligned_lock_latency: got %0d expected 17", k);
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL aligned_pulses: got %0d expected 0", pulses);
        end
        test_data_path(12, 4'hF);
    endtask

    task automatic test_offset3();
        int k;
        go_idle();
        n_tests++;
        if (O_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_unlock: got %b expected 0", O_locked);
        end
        rot = 3;
        pulses = 0;
        pulse_cyc.delete();
        en = 1'b1;
        wait_locked(100, k);
        n_tests++;
        if (k != 35) begin
            n_fail++;
            $display("FAIL offset3_lock_latency: got %0d expected 35", k);
        end
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL offset3_pulses: got %0d expected 3", pulses);
        end
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            n_tests++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 6) begin
                n_fail++;
                $display("FAIL slip_cadence[%0d]: got %0d expected 6", i, pulse_cyc[i] - pulse_cyc[i-1]);
            end
        end
        n_tests++;
        if (O_slip_pos !== 3'(exp_slip) || exp_slip != 3) begin
            n_fail++;
            $display("FAIL offset3_slip_pos: got %0d expected 3", O_slip_pos);
        end
    endtask

    task automatic test_never_match();
        int k;
        go_idle();
        use_force = 1'b1;
        force_word = 7'b0000000;
        pulses = 0;
        en = 1'b1;
        k = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (O_fail === 1'b1) begin
                k = i;
                break;
            end
        end
        n_tests++;
        if (k != 86) begin
            n_fail++;
            $display("FAIL fail_latency: got %0d expected 86", k);
        end
        n_tests++;
        if (pulses != 14) begin
            n_fail++;
            $display("FAIL fail_pulses: got %0d expected 14", pulses);
        end
        n_tests++;
        if (O_slip_pos !== 3'(exp_slip)) begin
            n_fail++;
            $display("FAIL slip_pos_wrap: got %0d expected %0d", O_slip_pos, exp_slip);
        end
        test_data_path(4, 4'h0);
        repeat (16) @(negedge clk);
        n_tests++;
        if (pulses != 14 || O_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL fail_sticky: got pulses=%0d fail=%b expected 14/1", pulses, O_fail);
        end
        go_idle();
        n_tests++;
        if (O_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_clear: got %b expected 0", O_fail);
        end
    endtask

    task automatic test_loss();
        int k;
        use_force = 1'b0;
        rot = 0;
        pulses = 0;
        en = 1'b1;
        wait_locked(40, k);
        n_tests++;
        if (k != 17) begin
            n_fail++;
            $display("FAIL loss_initial_lock: got %0d expected 17", k);
        end
        force_word = ~PAT;
        for (int i = 0; i < 3; i++) begin
            use_force = 1'b1;
            @(negedge clk);
            n_tests++;
            if (O_locked !== 1'b1) begin
                n_fail++;
                $display("FAIL loss_hold_burst1[%0d]: got %b expected 1", i, O_locked);
            end
        end
        use_force = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            use_force = 1'b1;
            @(negedge clk);
            n_tests++;
            if (O_locked !== (i < 3)) begin
                n_fail++;
                $display("FAIL loss_burst2[%0d]: got %b expected %b", i, O_locked, i < 3);
            end
        end
        use_force = 1'b0;
        wait_locked(40, k);
        n_tests++;
        if (k != 16 || pulses != 0) begin
            n_fail++;
            $display("FAIL relock: got latency=%0d pulses=%0d expected 16/0", k, pulses);
        end
        n_tests++;
        if (O_slip_pos !== 3'd3) begin
            n_fail++;
            $display("FAIL relock_slip_pos: got %0d expected 3", O_slip_pos);
        end
    endtask

    task automatic test_glitch_verify();
        int k;
        go_idle();
        rotate_en = 1'b0;
        rot = 0;
        use_force = 1'b0;
        pulses = 0;
        en = 1'b1;
        repeat (11) @(negedge clk);
        force_word = ~PAT;
        use_force = 1'b1;
        @(negedge clk);
        use_force = 1'b0;
        wait_locked(60, k);
        n_tests++;
        if (k != 21) begin
            n_fail++;
            $display("FAIL glitch_relock_latency: got %0d expected 21", k);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL glitch_pulses: got %0d expected 1", pulses);
        end
        rotate_en = 1'b1;
    endtask

    task automatic test_abort();
        go_idle();
        use_force = 1'b1;
        force_word = 7'b0000000;
        pulses = 0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (pulses != 1 || O_bitslip !== 1'b0 || O_locked !== 1'b0 || O_align_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_settle: got pulses=%0d slip=%b lock=%b valid=%b expected 1/0/0/0",
                     pulses, O_bitslip, O_locked, O_align_valid0);
        end
        pulses = 0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL enable_priority: got %0d pulses expected 0", pulses);
        end
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (O_bitslip !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_idle: got %b expected 1", O_bitslip);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        go_idle();
        use_force = 1'b0;
        rot = 0;
        en = 1'b1;
        repeat (8) @(negedge clk);
        lane0 = 7'h55; lane1 = 7'h2a; lane2 = 7'h7f; lane3 = 7'h01;
        @(negedge clk);
        n_tests++;
        if (O_slip_pos !== 3'(exp_slip) || O_align_data2 !== 7'h7f) begin
            n_fail++;
            $display("FAIL pre_reset_state: got pos=%0d data2=%h expected %0d/7f",
                     O_slip_pos, O_align_data2, exp_slip);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({O_bitslip, O_locked, O_fail, O_slip_pos, O_align_valid0, O_align_data0,
             O_align_data1, O_align_data2, O_align_data3} !== 35'd0) begin
            n_fail++;
            $display("FAIL async_reset: got pos=%0d lock=%b data=%h expected all 0",
                     O_slip_pos, O_locked, {O_align_data3, O_align_data2, O_align_data1, O_align_data0});
        end
        exp_slip = 0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned();
        test_offset3();
        test_never_match();
        test_loss();
        test_glitch_verify();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
